// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parametrised inter-stage pipeline buffer with optional skid entry and stall counter
module pipe_stage_buf #(
   parameter int                DATA_W         = 151,
   parameter logic [DATA_W-1:0] RST_DATA       = {DATA_W{1'b0}},
   parameter bit                SKID           = 1'b1,
   parameter bit                ZERO_ON_BUBBLE = 1'b1,
   parameter int                CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   input  logic              stall_cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   generate
      if (SKID) begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_TWO   = 2'd2
         } state_t;

         state_t            state_q;
         state_t            state_d;
         logic [DATA_W-1:0] main_q;
         logic [DATA_W-1:0] skid_q;
         logic              rdy_q;
         logic              in_xfer;
         logic              out_xfer;
         logic              main_from_in;
         logic              main_from_skid;
         logic              skid_from_in;

         // rdy_q is a flop so the upstream ready path never sees out_ready;
         // it is only masked by reset so nothing is accepted while held.
         assign in_ready  = rdy_q & rst;
         assign out_valid = (state_q != ST_EMPTY);
         assign out_data  = (ZERO_ON_BUBBLE && !out_valid) ? RST_DATA : main_q;
         assign occupancy = state_q;
         assign in_xfer   = in_valid & in_ready;
         assign out_xfer  = out_valid & out_ready;

         // Next state and payload steering; flush wins over both transfers.
         always_comb begin
            state_d        = state_q;
            main_from_in   = 1'b0;
            main_from_skid = 1'b0;
            skid_from_in   = 1'b0;
            if (flush) begin
               state_d = ST_EMPTY;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (in_xfer) begin
                        state_d      = ST_ONE;
                        main_from_in = 1'b1;
                     end
                  end
                  ST_ONE: begin
                     if (in_xfer && out_xfer) begin
                        main_from_in = 1'b1;
                     end else if (in_xfer) begin
                        state_d      = ST_TWO;
                        skid_from_in = 1'b1;
                     end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                     end
                  end
                  ST_TWO: begin
                     if (out_xfer) begin
                        state_d        = ST_ONE;
                        main_from_skid = 1'b1;
                     end
                  end
                  default: state_d = ST_EMPTY;
               endcase
            end
         end

         // State register plus the registered copy of "not full" for in_ready.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= ST_EMPTY;
               rdy_q   <= 1'b1;
            end else begin
               state_q <= state_d;
               rdy_q   <= (state_d != ST_TWO);
            end
         end

         // Payload entries: main always feeds the output, skid holds the overflow.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               main_q <= RST_DATA;
               skid_q <= RST_DATA;
            end else if (flush) begin
               if (ZERO_ON_BUBBLE) begin
                  main_q <= RST_DATA;
                  skid_q <= RST_DATA;
               end
            end else begin
               if (main_from_in) begin
                  main_q <= in_data;
               end else if (main_from_skid) begin
                  main_q <= skid_q;
               end
               if (skid_from_in) begin
                  skid_q <= in_data;
               end
            end
         end
      end else begin : g_reg
         logic              valid_q;
         logic [DATA_W-1:0] main_q;
         logic              in_xfer;
         logic              out_xfer;

         assign in_ready  = rst & (~valid_q | out_ready);
         assign out_valid = valid_q;
         assign out_data  = (ZERO_ON_BUBBLE && !valid_q) ? RST_DATA : main_q;
         assign occupancy = {1'b0, valid_q};
         assign in_xfer   = in_valid & in_ready;
         assign out_xfer  = valid_q & out_ready;

         // Single pipeline register; a new input replaces a departing one.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_q <= 1'b0;
               main_q  <= RST_DATA;
            end else if (flush) begin
               valid_q <= 1'b0;
               if (ZERO_ON_BUBBLE) begin
                  main_q <= RST_DATA;
               end
            end else if (in_xfer) begin
               valid_q <= 1'b1;
               main_q  <= in_data;
            end else if (out_xfer) begin
               valid_q <= 1'b0;
            end
         end
      end
   endgenerate

   // Back-pressure counter: saturates, clear beats increment, flush ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall_cnt_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // skid-mode instance, full width
   logic         s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_clr = 0;
   logic [150:0] s_in_data = '0, s_out_data;
   logic [1:0]   s_occ;
   logic [15:0]  s_stall;

   // single-register instance
   logic         r_flush = 0, r_in_valid = 0, r_in_ready, r_out_valid, r_out_ready = 0, r_clr = 0;
   logic [150:0] r_in_data = '0, r_out_data;
   logic [1:0]   r_occ;
   logic [15:0]  r_stall;

   // narrow counter instance
   logic         c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_clr = 0;
   logic [7:0]   c_in_data = '0, c_out_data;
   logic [1:0]   c_occ;
   logic [3:0]   c_stall;

   pipe_stage_buf #(.DATA_W(151), .SKID(1'b1), .ZERO_ON_BUBBLE(1'b1), .CNT_W(16)) u_skid (
      .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occ), .stall_cnt_clr(s_clr), .stall_cnt(s_stall));

   pipe_stage_buf #(.DATA_W(151), .SKID(1'b0), .ZERO_ON_BUBBLE(1'b1), .CNT_W(16)) u_reg (
      .clk(clk), .rst(rst), .flush(r_flush), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .in_data(r_in_data), .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
      .occupancy(r_occ), .stall_cnt_clr(r_clr), .stall_cnt(r_stall));

   pipe_stage_buf #(.DATA_W(8), .SKID(1'b1), .ZERO_ON_BUBBLE(1'b1), .CNT_W(4)) u_cnt (
      .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .occupancy(c_occ), .stall_cnt_clr(c_clr), .stall_cnt(c_stall));

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      // reset held from time zero
      tick();
      tick();
      check("rst_s_out_valid", s_out_valid, 0);
      check("rst_s_out_data", s_out_data, 0);
      check("rst_s_occ", s_occ, 0);
      check("rst_s_stall", s_stall, 0);
      check("rst_s_in_ready", s_in_ready, 0);
      check("rst_r_in_ready", r_in_ready, 0);
      rst = 1'b1;
      #1;
      check("post_rst_s_in_ready", s_in_ready, 1);
      check("post_rst_r_in_ready", r_in_ready, 1);

      // streaming through the skid instance
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_in_data = 151'(i);
         tick();
         check("stream_data", s_out_data, 160'(i));
         check("stream_valid", s_out_valid, 1);
         check("stream_occ", s_occ, 1);
      end
      s_in_valid = 1'b0;
      tick();
      check("stream_drain_valid", s_out_valid, 0);
      check("stream_bubble_data", s_out_data, 0);
      check("stream_stall", s_stall, 0);

      // back-pressure fills both entries
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 151'h11;
      tick();
      check("bp_a_occ", s_occ, 1);
      check("bp_a_stall", s_stall, 0);
      s_in_data = 151'h22;
      tick();
      check("bp_b_occ", s_occ, 2);
      check("bp_b_in_ready", s_in_ready, 0);
      check("bp_b_stall", s_stall, 1);
      check("bp_b_data", s_out_data, 160'h11);
      s_in_data = 151'h33;
      tick();
      check("bp_c_in_ready", s_in_ready, 0);
      check("bp_c_occ", s_occ, 2);
      check("bp_c_stall", s_stall, 2);
      s_out_ready = 1'b1;
      tick();
      check("bp_drain1_data", s_out_data, 160'h22);
      check("bp_drain1_occ", s_occ, 1);
      check("bp_drain1_in_ready", s_in_ready, 1);
      tick();
      check("bp_drain2_data", s_out_data, 160'h33);
      check("bp_drain2_occ", s_occ, 1);
      s_in_valid = 1'b0;
      tick();
      check("bp_empty_valid", s_out_valid, 0);
      check("bp_stall_hold", s_stall, 2);

      // flush while full, with a competing input and output
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 151'h55;
      tick();
      s_in_data = 151'h66;
      tick();
      check("fl_full_occ", s_occ, 2);
      check("fl_full_stall", s_stall, 3);
      s_flush     = 1'b1;
      s_in_data   = 151'h44;
      s_out_ready = 1'b1;
      tick();
      s_flush    = 1'b0;
      s_in_valid = 1'b0;
      check("fl_valid", s_out_valid, 0);
      check("fl_occ", s_occ, 0);
      check("fl_data", s_out_data, 0);
      check("fl_in_ready", s_in_ready, 1);
      check("fl_stall_kept", s_stall, 3);
      tick();
      check("fl_no_ghost", s_out_valid, 0);
      // flush with in_ready=1 still discards the input
      s_in_valid = 1'b1;
      s_in_data  = 151'h77;
      tick();
      check("fl1_loaded", s_out_data, 160'h77);
      s_flush   = 1'b1;
      s_in_data = 151'h88;
      #1;
      check("fl1_in_ready_high", s_in_ready, 1);
      tick();
      s_flush    = 1'b0;
      s_in_valid = 1'b0;
      check("fl1_valid", s_out_valid, 0);
      check("fl1_occ", s_occ, 0);
      tick();
      check("fl1_no_ghost", s_out_valid, 0);

      // single-register mode: combinational ready
      r_in_valid = 1'b1;
      r_in_data  = 151'hA1;
      tick();
      check("reg_valid", r_out_valid, 1);
      check("reg_data", r_out_data, 160'hA1);
      check("reg_occ", r_occ, 1);
      check("reg_in_ready_blocked", r_in_ready, 0);
      r_out_ready = 1'b1;
      r_in_data   = 151'hB2;
      #1;
      check("reg_in_ready_comb", r_in_ready, 1);
      tick();
      check("reg_next_data", r_out_data, 160'hB2);
      check("reg_next_valid", r_out_valid, 1);
      r_in_valid = 1'b0;
      tick();
      check("reg_drain_valid", r_out_valid, 0);
      check("reg_drain_data", r_out_data, 0);
      check("reg_drain_occ", r_occ, 0);
      check("reg_stall", r_stall, 0);
      r_out_ready = 1'b0;
      r_in_valid  = 1'b1;
      r_in_data   = 151'hC3;
      tick();
      r_flush   = 1'b1;
      r_in_data = 151'hD4;
      tick();
      r_flush    = 1'b0;
      r_in_valid = 1'b0;
      check("reg_flush_valid", r_out_valid, 0);
      check("reg_flush_in_ready", r_in_ready, 1);
      check("reg_stall_one", r_stall, 1);

      // saturating counter on the narrow instance
      c_in_valid = 1'b1;
      c_in_data  = 8'h5A;
      tick();
      c_in_valid = 1'b0;
      check("cnt_start", c_stall, 0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) check("cnt_14", c_stall, 14);
      end
      check("cnt_sat", c_stall, 15);
      check("cnt_data_held", c_out_data, 8'h5A);
      c_clr = 1'b1;
      tick();
      c_clr = 1'b0;
      check("cnt_clr", c_stall, 0);
      tick();
      tick();
      check("cnt_resume", c_stall, 2);

      // asynchronous reset in the middle of a cycle with both entries held
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 151'h99;
      tick();
      s_in_data = 151'hAA;
      tick();
      s_in_valid = 1'b0;
      check("mid_full_occ", s_occ, 2);
      check("mid_stall", s_stall, 4);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", s_out_valid, 0);
      check("mid_rst_occ", s_occ, 0);
      check("mid_rst_data", s_out_data, 0);
      check("mid_rst_stall", s_stall, 0);
      check("mid_rst_in_ready", s_in_ready, 0);
      tick();
      rst = 1'b1;
      #1;
      check("mid_rel_in_ready", s_in_ready, 1);
      check("mid_rel_valid", s_out_valid, 0);
      tick();
      check("mid_no_ghost", s_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
